// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit; the ISA decoder imports the op codes too.
package mdu_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mduOp_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mduState_e;

  typedef enum logic {
    CORE_MUL = 1'b0,
    CORE_DIV = 1'b1
  } coreMode_e;

  // With a combinational multiplier only the divides go through the iterative path.
  function automatic logic isIterOp(input logic [2:0] op, input logic fastMul);
    logic isDiv;
    logic isMul;
    isDiv = (op == MDU_DIV) || (op == MDU_DIVU);
    isMul = (op == MDU_MULT) || (op == MDU_MULTU);
    return isDiv || (isMul && !fastMul);
  endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// EX-stage to MDU connection: issue side (start/op/operands) and HI/LO/ready return.
interface mdu_unit_if #(
  parameter int XLEN = mdu_pkg::XLEN_DEFAULT
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            ready;

  modport master (
    output start, op, src_a, src_b,
    input  hi, lo, ready
  );

  modport slave (
    input  start, op, src_a, src_b,
    output hi, lo, ready
  );
endinterface

// File: rtl/mdu_iter_core.sv
// One-bit-per-cycle datapath: shift-add multiply or restoring divide on unsigned magnitudes.
// result is the {acc,shreg} value after the current step (current value when step is low).
module mdu_iter_core
  import mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              step,
  input  coreMode_e         mode,
  input  logic [XLEN-1:0]   opA,
  input  logic [XLEN-1:0]   opB,
  output logic [2*XLEN-1:0] result
);

  coreMode_e       modeReg;
  logic [XLEN-1:0] accReg;
  logic [XLEN-1:0] shReg;
  logic [XLEN-1:0] operandReg;

  logic [XLEN-1:0] partial;
  logic [XLEN:0]   addSum;
  logic [XLEN:0]   remTrial;
  logic [XLEN:0]   remDiff;
  logic            remFits;
  logic [XLEN-1:0] accNext;
  logic [XLEN-1:0] shNext;
  logic            unusedBits;

  // Multiplicand gated by the current multiplier LSB.
  for (genvar gi = 0; gi < XLEN; gi++) begin : genPartial
    assign partial[gi] = operandReg[gi] & shReg[0];
  end

  always_comb begin
    addSum   = {1'b0, accReg} + {1'b0, partial};
    remTrial = {accReg, shReg[XLEN-1]};
    remDiff  = remTrial - {1'b0, operandReg};
    remFits  = (remTrial >= {1'b0, operandReg});
    if (modeReg == CORE_MUL) begin
      accNext = addSum[XLEN:1];
      shNext  = {addSum[0], shReg[XLEN-1:1]};
    end else begin
      accNext = remFits ? remDiff[XLEN-1:0] : remTrial[XLEN-1:0];
      shNext  = {shReg[XLEN-2:0], remFits};
    end
  end

  // The remainder never exceeds the divisor, so the top difference bit carries nothing.
  assign unusedBits = remDiff[XLEN];

  assign result = step ? {accNext, shNext} : {accReg, shReg};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      modeReg    <= CORE_MUL;
      accReg     <= '0;
      shReg      <= '0;
      operandReg <= '0;
    end else if (load) begin
      modeReg    <= mode;
      accReg     <= '0;
      shReg      <= (mode == CORE_MUL) ? opB : opA;
      operandReg <= (mode == CORE_MUL) ? opA : opB;
    end else if (step) begin
      accReg <= accNext;
      shReg  <= shNext;
    end
  end

endmodule

// File: rtl/mdu_unit.sv
// EX-stage multiply/divide unit owning HI/LO; iterative MULT/DIV, single-cycle MTHI/MTLO.
// Define MDU_FAST_MUL_EN to replace the iterative multiply with a one-cycle combinational one.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int XLEN        = XLEN_DEFAULT,
  parameter int ITER_CYCLES = XLEN
) (
  input logic       clk,
  input logic       resetn,
  mdu_unit_if.slave bus
);

  localparam int CNT_W = (ITER_CYCLES > 1) ? $clog2(ITER_CYCLES) : 1;
`ifdef MDU_FAST_MUL_EN
  localparam logic FAST_MUL = 1'b1;
`else
  localparam logic FAST_MUL = 1'b0;
`endif

  mduState_e         stateReg;
  logic [CNT_W-1:0]  counterReg;
  logic [XLEN-1:0]   hiReg;
  logic [XLEN-1:0]   loReg;
  logic [XLEN-1:0]   origAReg;
  logic              isDivReg;
  logic              negResReg;
  logic              negRemReg;
  logic              divZeroReg;

  logic              isDivOp;
  logic              isSigned;
  logic              signA;
  logic              signB;
  logic [XLEN-1:0]   magA;
  logic [XLEN-1:0]   magB;
  logic              iterStart;
  logic              stepEn;
  coreMode_e         coreMode;
  logic [2*XLEN-1:0] coreResult;
  logic [XLEN-1:0]   hiFinal;
  logic [XLEN-1:0]   loFinal;

  always_comb begin
    isDivOp   = (bus.op == MDU_DIV) || (bus.op == MDU_DIVU);
    isSigned  = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
    signA     = isSigned & bus.src_a[XLEN-1];
    signB     = isSigned & bus.src_b[XLEN-1];
    magA      = signA ? -bus.src_a : bus.src_a;
    magB      = signB ? -bus.src_b : bus.src_b;
    iterStart = (stateReg == IDLE) && bus.start && isIterOp(bus.op, FAST_MUL);
    stepEn    = (stateReg == BUSY);
    coreMode  = isDivOp ? CORE_DIV : CORE_MUL;
  end

  mdu_iter_core #(
    .XLEN(XLEN)
  ) iterCore (
    .clk   (clk),
    .resetn(resetn),
    .load  (iterStart),
    .step  (stepEn),
    .mode  (coreMode),
    .opA   (magA),
    .opB   (magB),
    .result(coreResult)
  );

  // Sign restoration and divide-by-zero override on the final step's value.
  always_comb begin
    hiFinal = coreResult[2*XLEN-1:XLEN];
    loFinal = coreResult[XLEN-1:0];
    if (!isDivReg) begin
      if (negResReg) begin
        {hiFinal, loFinal} = -coreResult;
      end
    end else if (divZeroReg) begin
      hiFinal = origAReg;
      loFinal = '1;
    end else begin
      if (negResReg) loFinal = -coreResult[XLEN-1:0];
      if (negRemReg) hiFinal = -coreResult[2*XLEN-1:XLEN];
    end
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fastProd;
  always_comb begin
    if (bus.op == MDU_MULT) begin
      fastProd = {{XLEN{bus.src_a[XLEN-1]}}, bus.src_a} * {{XLEN{bus.src_b[XLEN-1]}}, bus.src_b};
    end else begin
      fastProd = {{XLEN{1'b0}}, bus.src_a} * {{XLEN{1'b0}}, bus.src_b};
    end
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stateReg   <= IDLE;
      counterReg <= '0;
      hiReg      <= '0;
      loReg      <= '0;
      origAReg   <= '0;
      isDivReg   <= 1'b0;
      negResReg  <= 1'b0;
      negRemReg  <= 1'b0;
      divZeroReg <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (bus.start) begin
            case (bus.op)
              MDU_MTHI: hiReg <= bus.src_a;
              MDU_MTLO: loReg <= bus.src_a;
`ifdef MDU_FAST_MUL_EN
              MDU_MULT, MDU_MULTU: {hiReg, loReg} <= fastProd;
`endif
              default: ;
            endcase
          end
          if (iterStart) begin
            stateReg   <= BUSY;
            counterReg <= CNT_W'(ITER_CYCLES - 1);
            origAReg   <= bus.src_a;
            isDivReg   <= isDivOp;
            negResReg  <= signA ^ signB;
            negRemReg  <= signA;
            divZeroReg <= (bus.src_b == '0);
          end
        end
        BUSY: begin
          counterReg <= counterReg - CNT_W'(1);
          if (counterReg == '0) begin
            stateReg <= DONE;
            hiReg    <= hiFinal;
            loReg    <= loFinal;
          end
        end
        // The issuing instruction is still in EX here, so start is not looked at.
        DONE:    stateReg <= IDLE;
        default: stateReg <= IDLE;
      endcase
    end
  end

  assign bus.hi    = hiReg;
  assign bus.lo    = loReg;
  assign bus.ready = ((stateReg == IDLE) && !iterStart) || (stateReg == DONE);

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: latency, signed/unsigned results, MT ops, back-to-back and reset abort.
`timescale 1ns/1ps
module tb_mdu_unit;
  import mdu_pkg::*;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  int   checkCount = 0;
  int   passCount  = 0;
  int   failCount  = 0;
  int   stall;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_STALL = 0;
`else
  localparam int MUL_STALL = 33;
`endif
  localparam int DIV_STALL = 33;

  mdu_unit_if #(.XLEN(32)) bus ();

  mdu_unit #(
    .XLEN(32),
    .ITER_CYCLES(32)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues an op at a negedge and counts ready=0 samples until ready returns (bounded).
  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int stallCycles);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    stallCycles = 0;
    #1;
    while (!bus.ready && stallCycles < 100) begin
      stallCycles++;
      @(negedge clk);
      bus.src_a = $urandom;
      bus.src_b = $urandom;
      #1;
    end
    if (stallCycles == 0) begin
      @(negedge clk);
      #1;
    end
    $display("op=%0d a=0x%08h b=0x%08h stall=%0d hi=0x%08h lo=0x%08h",
             op, a, b, stallCycles, bus.hi, bus.lo);
  endtask

  task automatic checkOp(input string tag, input int stallCycles, input int expStall,
                         input logic [31:0] expHi, input logic [31:0] expLo);
    check({tag, " stall"}, 64'(stallCycles), 64'(expStall));
    check({tag, " hi"}, {32'h0, bus.hi}, {32'h0, expHi});
    check({tag, " lo"}, {32'h0, bus.lo}, {32'h0, expLo});
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.src_a = '0;
    bus.src_b = '0;
    #2 resetn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset hi", {32'h0, bus.hi}, 64'h0);
    check("reset lo", {32'h0, bus.lo}, 64'h0);
    check("reset ready", {63'h0, bus.ready}, 64'h1);
    @(negedge clk);
    resetn = 1'b1;

    runOp(MDU_MULT, 32'hFFFFFFFE, 32'h3, stall);
    checkOp("MULT -2*3", stall, MUL_STALL, 32'hFFFFFFFF, 32'hFFFFFFFA);
    runOp(MDU_MULTU, 32'hFFFFFFFE, 32'h3, stall);
    checkOp("MULTU", stall, MUL_STALL, 32'h00000002, 32'hFFFFFFFA);
    runOp(MDU_DIV, 32'hFFFFFFF9, 32'h2, stall);
    checkOp("DIV -7/2", stall, DIV_STALL, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp(MDU_DIVU, 32'hFFFFFFF9, 32'h2, stall);
    checkOp("DIVU", stall, DIV_STALL, 32'h00000001, 32'h7FFFFFFC);
    runOp(MDU_DIVU, 32'h00001234, 32'h0, stall);
    checkOp("DIVU by zero", stall, DIV_STALL, 32'h00001234, 32'hFFFFFFFF);
    runOp(MDU_DIV, 32'hFFFFFFF9, 32'h0, stall);
    checkOp("DIV by zero", stall, DIV_STALL, 32'hFFFFFFF9, 32'hFFFFFFFF);
    runOp(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, stall);
    checkOp("DIV overflow", stall, DIV_STALL, 32'h00000000, 32'h80000000);

    // MTHI then MTLO in consecutive cycles
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = MDU_MTHI;
    bus.src_a = 32'hA5A5A5A5;
    #1;
    check("MTHI ready", {63'h0, bus.ready}, 64'h1);
    @(negedge clk);
    check("MTHI hi", {32'h0, bus.hi}, 64'hA5A5A5A5);
    check("MTHI lo kept", {32'h0, bus.lo}, 64'h80000000);
    bus.op    = MDU_MTLO;
    bus.src_a = 32'h5A5A5A5A;
    #1;
    check("MTLO ready", {63'h0, bus.ready}, 64'h1);
    @(negedge clk);
    check("MTLO lo", {32'h0, bus.lo}, 64'h5A5A5A5A);
    check("MTLO hi kept", {32'h0, bus.hi}, 64'hA5A5A5A5);
    bus.start = 1'b0;
    #1;
    check("idle ready", {63'h0, bus.ready}, 64'h1);
    $display("MTHI/MTLO hi=0x%08h lo=0x%08h", bus.hi, bus.lo);

    // DIV held through DONE, MULT enters EX on the very next cycle
    runOp(MDU_DIV, 32'd100, 32'd7, stall);
    checkOp("DIV 100/7", stall, DIV_STALL, 32'd2, 32'd14);
    runOp(MDU_MULT, 32'hFFFFFFFF, 32'd5, stall);
    checkOp("MULT after DIV", stall, MUL_STALL, 32'hFFFFFFFF, 32'hFFFFFFFB);
    runOp(MDU_MULTU, 32'h00010000, 32'h00010000, stall);
    checkOp("MULTU 2^16*2^16", stall, MUL_STALL, 32'h00000001, 32'h00000000);
    runOp(MDU_MULT, 32'h00010000, 32'h00010000, stall);
    checkOp("MULT 2^16*2^16", stall, MUL_STALL, 32'h00000001, 32'h00000000);
    runOp(MDU_MULT, 32'hFFFFFFF9, 32'hFFFFFFFD, stall);
    checkOp("MULT -7*-3", stall, MUL_STALL, 32'h00000000, 32'h00000015);

    // Reset in the middle of a DIVU discards it
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = MDU_DIVU;
    bus.src_a = 32'd1000;
    bus.src_b = 32'd3;
    repeat (10) @(negedge clk);
    #2;
    bus.start = 1'b0;
    resetn    = 1'b0;
    #1;
    check("abort hi", {32'h0, bus.hi}, 64'h0);
    check("abort lo", {32'h0, bus.lo}, 64'h0);
    check("abort ready", {63'h0, bus.ready}, 64'h1);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check("no late write lo", {32'h0, bus.lo}, 64'h0);
    check("post-reset ready", {63'h0, bus.ready}, 64'h1);
    $display("reset abort hi=0x%08h lo=0x%08h ready=%0b", bus.hi, bus.lo, bus.ready);
    runOp(MDU_MULTU, 32'd3, 32'd5, stall);
    checkOp("MULTU 3*5", stall, MUL_STALL, 32'd0, 32'd15);

    @(negedge clk);
    bus.start = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline. Owns the HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU iteratively and MTHI/MTLO in one cycle.
- Drives ready (MDUReadyE) to the hazard unit. While ready=0 the hazard unit stalls F/D/E, so the issuing instruction stays in EX with start held high.

Parameters:
- XLEN, 32, operand and HI/LO width.
- ITER_CYCLES, 32, BUSY cycles per iterative op; must equal XLEN (one bit per cycle).

Ports:
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  EX-stage instruction is an MDU op (already gated by the EX valid bit)
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved (no-op)
- src_a  in  XLEN  rs value (forwarded); dividend / multiplicand / MT source
- src_b  in  XLEN  rt value (forwarded); divisor / multiplier
- hi  out  XLEN  HI register
- lo  out  XLEN  LO register
- ready  out  1  0 = hold pipeline (MDUReadyE)

Behaviour:
- Reset, asynchronous, any state: state=IDLE, hi=0, lo=0, counter=0, internal datapath cleared. ready=1 after reset (IDLE, start low). An operation in flight when reset asserts is discarded, with no HI/LO write.
- States:
  - IDLE: start & op in {0..3} -> BUSY. Operands are latched, magnitudes taken for signed ops, counter=ITER_CYCLES-1.
  - BUSY: counter decrements each cycle. When counter==0 -> DONE, and HI/LO are written on that edge.
  - DONE: -> IDLE unconditionally. start is ignored here, because the same instruction is still in EX.
- ready is combinational:
  - ready = (IDLE & ~(start & op<=3)) | DONE.
  - The start cycle therefore already stalls.
  - Total stall is 1 + ITER_CYCLES cycles (33). ready=1 in DONE lets the instruction leave EX.
- MTHI/MTLO, in IDLE with start:
  - hi or lo := src_a on that edge; ready stays 1; no state change.
  - Ignored in BUSY/DONE (cannot occur, since the pipeline is stalled).
- Multiply: shift-add on magnitudes, one multiplier bit per cycle. {hi,lo} = 64-bit product.
  - Signed: product negated (two's complement, 64-bit) when the operand signs differ.
- Divide: restoring, one quotient bit per cycle. lo=quotient, hi=remainder.
  - Signed: quotient negated when signs differ; remainder takes the sign of the dividend.
  - -2^31 / -1 gives lo=0x80000000, hi=0.
- Divide by zero (src_b==0), signed or unsigned: still takes the full latency. Result lo=0xFFFFFFFF, hi=src_a (the original value, not the magnitude).
- Back-to-back MDU ops: the second op reaches EX in the cycle after DONE, sees IDLE and starts normally, with no lost cycle beyond latency.
- A following MFHI/MFLO in EX reads hi/lo, which have been valid since the DONE edge.
- Operands are latched at start, so src_a/src_b changes during BUSY have no effect.

Optional Feature:
- Macro MDU_FAST_MUL_EN.
- Defined:
  - MULT/MULTU use a combinational XLEN x XLEN multiply (signed/unsigned per op).
  - {hi,lo} is written on the start edge in IDLE, exactly like MTHI. ready stays 1 (no stall).
  - DIV/DIVU are unchanged.
- Undefined: the iterative multiply described above, with 33-cycle stall.

Decomposition:
- Shared package mdu_pkg:
  - op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO)
  - state encoding (IDLE/BUSY/DONE)
  - XLEN default
- The ISA decoder also imports the op encodings.
- One sub-module, mdu_iter_core: per-cycle shift-add/restoring datapath with mode input, step enable and 64-bit {acc,shreg} result.
- mdu_unit keeps the FSM, counter, sign handling, HI/LO and ready logic.

Test Plan:
- MULT: start, op=0, src_a=0xFFFFFFFE (-2), src_b=3.
  - ready=0 for 33 cycles, then 1 for one DONE cycle.
  - hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - Repeat as MULTU: hi=0x00000002, lo=0xFFFFFFFA.
- DIV, op=2, src_a=-7 (0xFFFFFFF9), src_b=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU with the same operands: lo=0x7FFFFFFC, hi=1.
- DIVU by zero, src_a=0x1234, src_b=0: latency 33, lo=0xFFFFFFFF, hi=0x1234.
  - DIV with src_a=0x80000000, src_b=0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI src_a=0xA5A5A5A5, then MTLO src_a=0x5A5A5A5A in consecutive cycles: ready constant 1, hi/lo updated on each edge.
  - Then DIV held through DONE, directly followed by MULT: the second op starts on the cycle after DONE; no double start.
- Reset: assert resetn=0 at cycle 10 of a DIVU.
  - hi=lo=0 and ready=1 immediately.
  - After release, a new MULTU 3*5 gives lo=15, hi=0.
- MDU_FAST_MUL_EN defined: MULT 0x10000 * 0x10000 with ready never dropping; hi=1, lo=0 on the start edge. A DIV still stalls 33 cycles.
